// File: rtl/mem_check_monitor.sv
// Passive run-to-completion monitor: snoops data-memory writes, detects PC halt or timeout, then scores expected entries.
// Define MEM_CHECK_MONITOR_DISPLAY_EN for simulation-only $display reporting (mismatches, timeout, final verdict).
module mem_check_monitor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CHECKS     = 4,
  parameter int HALT_REPEAT    = 4,
  parameter int TIMEOUT_CYCLES = 200,
  localparam int IDX_WIDTH     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  input  logic                  memWriteEn,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memWriteData,
  input  logic                  cfgWe,
  input  logic [IDX_WIDTH-1:0]  cfgIdx,
  input  logic [ADDR_WIDTH-1:0] cfgAddr,
  input  logic [DATA_WIDTH-1:0] cfgData,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [IDX_WIDTH-1:0]  failIdx,
  output logic [31:0]           cycleCount,
  output logic [31:0]           writeCount
);

  localparam int STB_WIDTH = $clog2(HALT_REPEAT);

  typedef enum logic [1:0] {RUN, CHECK, DONE} state_t;

  state_t                                r_state;
  logic [31:0]                           r_pcQ;
  logic [STB_WIDTH-1:0]                  r_stable;
  logic [NUM_CHECKS-1:0]                 r_valid;
  logic [NUM_CHECKS-1:0]                 r_written;
  logic [NUM_CHECKS-1:0][ADDR_WIDTH-1:0] r_expAddr;
  logic [NUM_CHECKS-1:0][DATA_WIDTH-1:0] r_expData;
  logic [NUM_CHECKS-1:0][DATA_WIDTH-1:0] r_seenData;
  logic [IDX_WIDTH-1:0]                  r_scanIdx;
  logic                                  r_failSeen;
  logic                                  r_done;
  logic                                  r_pass;
  logic                                  r_timeout;
  logic [IDX_WIDTH-1:0]                  r_failIdx;
  logic [31:0]                           r_cycleCount;
  logic [31:0]                           r_writeCount;

  logic                                  w_halt;
  logic                                  w_timeoutHit;
  logic                                  w_curValid;
  logic                                  w_curWritten;
  logic [DATA_WIDTH-1:0]                 w_curExp;
  logic [DATA_WIDTH-1:0]                 w_curSeen;
  logic                                  w_curFail;
  logic                                  w_lastScan;
  logic                                  w_verdictPass;

  assign w_halt       = (r_stable == STB_WIDTH'(HALT_REPEAT - 1));
  assign w_timeoutHit = (r_cycleCount == 32'(TIMEOUT_CYCLES - 1));
  assign w_lastScan   = (r_scanIdx == IDX_WIDTH'(NUM_CHECKS - 1));

  always_comb begin
    w_curValid   = 1'b0;
    w_curWritten = 1'b0;
    w_curExp     = '0;
    w_curSeen    = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (r_scanIdx == IDX_WIDTH'(i)) begin
        w_curValid   = r_valid[i];
        w_curWritten = r_written[i];
        w_curExp     = r_expData[i];
        w_curSeen    = r_seenData[i];
      end
    end
  end

  assign w_curFail     = w_curValid && (!w_curWritten || (w_curSeen != w_curExp));
  assign w_verdictPass = !r_timeout && !r_failSeen && !w_curFail;

  // Halt compares against the registered stable count, so the FSM leaves RUN one edge after
  // the count reaches HALT_REPEAT-1; a same-edge timeout loses to halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_pcQ        <= '0;
      r_stable     <= '0;
      r_valid      <= '0;
      r_written    <= '0;
      r_expAddr    <= '0;
      r_expData    <= '0;
      r_seenData   <= '0;
      r_scanIdx    <= '0;
      r_failSeen   <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_failIdx    <= '0;
      r_cycleCount <= '0;
      r_writeCount <= '0;
    end else begin
      case (r_state)
        RUN: begin
          r_pcQ <= pc;
          if (pc != r_pcQ) begin
            r_stable <= '0;
          end else if (!w_halt) begin
            r_stable <= r_stable + STB_WIDTH'(1);
          end
          if (r_cycleCount != '1) begin
            r_cycleCount <= r_cycleCount + 32'd1;
          end
          if (memWriteEn && (r_writeCount != '1)) begin
            r_writeCount <= r_writeCount + 32'd1;
          end
          // Configuration of an entry overrides a snoop hit on that entry in the same cycle.
          for (int i = 0; i < NUM_CHECKS; i++) begin
            if (cfgWe && (cfgIdx == IDX_WIDTH'(i))) begin
              r_valid[i]   <= 1'b1;
              r_expAddr[i] <= cfgAddr;
              r_expData[i] <= cfgData;
              r_written[i] <= 1'b0;
            end else if (memWriteEn && r_valid[i] && (r_expAddr[i] == memAddr)) begin
              r_written[i]  <= 1'b1;
              r_seenData[i] <= memWriteData;
            end
          end
          if (w_halt) begin
            r_state    <= CHECK;
            r_scanIdx  <= '0;
            r_failSeen <= 1'b0;
          end else if (w_timeoutHit) begin
            r_state    <= CHECK;
            r_scanIdx  <= '0;
            r_failSeen <= 1'b0;
            r_timeout  <= 1'b1;
          end
        end
        CHECK: begin
          if (w_curFail && !r_failSeen) begin
            r_failSeen <= 1'b1;
            r_failIdx  <= r_scanIdx;
          end
          if (w_lastScan) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_pass  <= w_verdictPass;
          end else begin
            r_scanIdx <= r_scanIdx + IDX_WIDTH'(1);
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign done       = r_done;
  assign pass       = r_pass;
  assign timeout    = r_timeout;
  assign failIdx    = r_failIdx;
  assign cycleCount = r_cycleCount;
  assign writeCount = r_writeCount;

`ifdef MEM_CHECK_MONITOR_DISPLAY_EN
  logic [ADDR_WIDTH-1:0] w_curAddr;

  always_comb begin
    w_curAddr = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (r_scanIdx == IDX_WIDTH'(i)) begin
        w_curAddr = r_expAddr[i];
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if ((r_state == RUN) && !w_halt && w_timeoutHit) begin
        $display("[mem_check_monitor] timeout after %0d cycles", r_cycleCount + 32'd1);
      end
      if ((r_state == CHECK) && w_curFail) begin
        $display("[mem_check_monitor] mismatch idx=%0d addr=0x%0h expected=0x%0h seen=0x%0h written=%0b",
                 r_scanIdx, w_curAddr, w_curExp, w_curSeen, w_curWritten);
      end
      if ((r_state == CHECK) && w_lastScan) begin
        $display("[mem_check_monitor] %s cycleCount=%0d", w_verdictPass ? "PASS" : "FAIL", r_cycleCount);
      end
    end
  end
`else
  // Synthesizable build: port behaviour only, no reporting.
`endif

endmodule

// File: tb/tb_mem_check_monitor.sv
// Self-checking bench for mem_check_monitor: table of configure/write/halt scenarios plus
// hand-written sequences for timeout, halt-vs-timeout, DONE hold, same-cycle cfg and mid-CHECK reset.
module tb_mem_check_monitor;

  localparam int NC = 4;
  localparam int HR = 4;
  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        memWriteEn;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        cfgWe;
  logic [1:0]  cfgIdx;
  logic [31:0] cfgAddr;
  logic [31:0] cfgData;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [1:0]  failIdx;
  logic [31:0] cycleCount;
  logic [31:0] writeCount;

  int testsRun    = 0;
  int testsFailed = 0;
  int edgeNo;
  int holdAt;
  int preHold;

  typedef struct {
    string                 name;
    logic [NC-1:0]         valid;
    logic [NC-1:0][31:0]   addr;
    logic [NC-1:0][31:0]   data;
    int                    nWr;
    logic [3:0][31:0]      wAddr;
    logic [3:0][31:0]      wData;
    logic                  expPass;
    logic [1:0]            expFailIdx;
    int                    expWrites;
  } scenario_t;

  scenario_t vec[6];

  mem_check_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_CHECKS(NC), .HALT_REPEAT(HR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .memWriteEn(memWriteEn), .memAddr(memAddr), .memWriteData(memWriteData),
    .cfgWe(cfgWe), .cfgIdx(cfgIdx), .cfgAddr(cfgAddr), .cfgData(cfgData),
    .done(done), .pass(pass), .timeout(timeout), .failIdx(failIdx),
    .cycleCount(cycleCount), .writeCount(writeCount)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock: PC advances by 4 per edge until holdAt, then freezes (the halt self-loop).
  task automatic tick();
    edgeNo++;
    if (edgeNo < holdAt) pc = 32'h100 + 32'(4 * edgeNo);
    else                 pc = 32'h100 + 32'(4 * holdAt);
    @(posedge clk);
    #1;
    cfgWe      = 1'b0;
    memWriteEn = 1'b0;
  endtask

  task automatic applyReset();
    reset        = 1'b1;
    cfgWe        = 1'b0;
    cfgIdx       = '0;
    cfgAddr      = '0;
    cfgData      = '0;
    memWriteEn   = 1'b0;
    memAddr      = '0;
    memWriteData = '0;
    pc           = '0;
    edgeNo       = 0;
    holdAt       = 1 << 30;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int k);
    for (int i = 0; i < NC; i++) begin
      if (vec[k].valid[i]) begin
        cfgWe   = 1'b1;
        cfgIdx  = 2'(i);
        cfgAddr = vec[k].addr[i];
        cfgData = vec[k].data[i];
        tick();
      end
    end
    for (int j = 0; j < vec[k].nWr; j++) begin
      memWriteEn   = 1'b1;
      memAddr      = vec[k].wAddr[j];
      memWriteData = vec[k].wData[j];
      tick();
    end
  endtask

  task automatic waitDone(output int lat);
    holdAt  = edgeNo + 1;
    preHold = edgeNo;
    lat     = 0;
    while (!done && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  // Done lands HR edges to reach the halt count, then NUM_CHECKS+1 more.
  task automatic runScenario(input int k);
    int lat;
    applyReset();
    applyStimulus(k);
    waitDone(lat);
    checkOutput({vec[k].name, " done"},       32'(done),     32'd1);
    checkOutput({vec[k].name, " latency"},    32'(lat),      32'(HR + NC + 1));
    checkOutput({vec[k].name, " pass"},       32'(pass),     32'(vec[k].expPass));
    checkOutput({vec[k].name, " timeout"},    32'(timeout),  32'd0);
    checkOutput({vec[k].name, " failIdx"},    32'(failIdx),  32'(vec[k].expFailIdx));
    checkOutput({vec[k].name, " writeCount"}, writeCount,    32'(vec[k].expWrites));
    checkOutput({vec[k].name, " cycleCount"}, cycleCount,    32'(preHold + HR + 1));
  endtask

  function automatic scenario_t blank(input string name);
    scenario_t s;
    s.name = name; s.valid = '0; s.addr = '0; s.data = '0; s.nWr = 0;
    s.wAddr = '0; s.wData = '0; s.expPass = 1'b0; s.expFailIdx = '0; s.expWrites = 0;
    return s;
  endfunction

  initial begin
    int lat;
    int ccHeld;

    vec[0] = blank("accum_pass");
    vec[0].valid = 4'b0001; vec[0].addr[0] = 32'hC; vec[0].data[0] = 32'd45;
    vec[0].nWr = 1; vec[0].wAddr[0] = 32'hC; vec[0].wData[0] = 32'd45;
    vec[0].expPass = 1'b1; vec[0].expFailIdx = 2'd0; vec[0].expWrites = 1;

    vec[1] = blank("accum_wrong_value");
    vec[1].valid = 4'b0001; vec[1].addr[0] = 32'hC; vec[1].data[0] = 32'd45;
    vec[1].nWr = 1; vec[1].wAddr[0] = 32'hC; vec[1].wData[0] = 32'd44;
    vec[1].expPass = 1'b0; vec[1].expFailIdx = 2'd0; vec[1].expWrites = 1;

    vec[2] = blank("entry2_unwritten");
    vec[2].valid = 4'b0111;
    vec[2].addr[0] = 32'h20; vec[2].data[0] = 32'd1;
    vec[2].addr[1] = 32'h24; vec[2].data[1] = 32'd2;
    vec[2].addr[2] = 32'h28; vec[2].data[2] = 32'd3;
    vec[2].nWr = 2;
    vec[2].wAddr[0] = 32'h20; vec[2].wData[0] = 32'd1;
    vec[2].wAddr[1] = 32'h24; vec[2].wData[1] = 32'd2;
    vec[2].expPass = 1'b0; vec[2].expFailIdx = 2'd2; vec[2].expWrites = 2;

    vec[3] = blank("last_write_wins");
    vec[3].valid = 4'b0001; vec[3].addr[0] = 32'hC; vec[3].data[0] = 32'd45;
    vec[3].nWr = 2;
    vec[3].wAddr[0] = 32'hC; vec[3].wData[0] = 32'd7;
    vec[3].wAddr[1] = 32'hC; vec[3].wData[1] = 32'd45;
    vec[3].expPass = 1'b1; vec[3].expFailIdx = 2'd0; vec[3].expWrites = 2;

    vec[4] = blank("full_addr_and_unmatched");
    vec[4].valid = 4'b0011;
    vec[4].addr[0] = 32'hC;  vec[4].data[0] = 32'd45;
    vec[4].addr[1] = 32'h30; vec[4].data[1] = 32'd5;
    vec[4].nWr = 4;
    vec[4].wAddr[0] = 32'hC;  vec[4].wData[0] = 32'd45;
    vec[4].wAddr[1] = 32'hE;  vec[4].wData[1] = 32'd9;
    vec[4].wAddr[2] = 32'h10; vec[4].wData[2] = 32'd99;
    vec[4].wAddr[3] = 32'h30; vec[4].wData[3] = 32'd5;
    vec[4].expPass = 1'b1; vec[4].expFailIdx = 2'd0; vec[4].expWrites = 4;

    vec[5] = blank("lowest_fail_skip_invalid");
    vec[5].valid = 4'b1010;
    vec[5].addr[0] = 32'h44; vec[5].data[0] = 32'd9;
    vec[5].addr[1] = 32'h40; vec[5].data[1] = 32'd1;
    vec[5].addr[3] = 32'h48; vec[5].data[3] = 32'd3;
    vec[5].nWr = 2;
    vec[5].wAddr[0] = 32'h40; vec[5].wData[0] = 32'd2;
    vec[5].wAddr[1] = 32'h48; vec[5].wData[1] = 32'd4;
    vec[5].expPass = 1'b0; vec[5].expFailIdx = 2'd1; vec[5].expWrites = 2;

    applyReset();
    checkOutput("reset done",       32'(done),    32'd0);
    checkOutput("reset pass",       32'(pass),    32'd0);
    checkOutput("reset timeout",    32'(timeout), 32'd0);
    checkOutput("reset failIdx",    32'(failIdx), 32'd0);
    checkOutput("reset cycleCount", cycleCount,   32'd0);
    checkOutput("reset writeCount", writeCount,   32'd0);

    for (int k = 0; k < 6; k++) runScenario(k);

    // DONE ignores cfg, writes and PC motion.
    runScenario(0);
    ccHeld = preHold + HR + 1;
    holdAt = 1 << 30;
    for (int n = 0; n < 3; n++) begin
      cfgWe = 1'b1; cfgIdx = 2'd1; cfgAddr = 32'h50; cfgData = 32'd1;
      memWriteEn = 1'b1; memAddr = 32'hC; memWriteData = 32'd3;
      tick();
    end
    checkOutput("done_hold done",       32'(done), 32'd1);
    checkOutput("done_hold pass",       32'(pass), 32'd1);
    checkOutput("done_hold writeCount", writeCount, 32'd1);
    checkOutput("done_hold cycleCount", cycleCount, 32'(ccHeld));

    // cfgWe and a matching write on the same edge: cfg wins, entry stays unwritten.
    applyReset();
    cfgWe = 1'b1; cfgIdx = 2'd0; cfgAddr = 32'hC; cfgData = 32'd45;
    tick();
    cfgWe = 1'b1; cfgIdx = 2'd0; cfgAddr = 32'hC; cfgData = 32'd45;
    memWriteEn = 1'b1; memAddr = 32'hC; memWriteData = 32'd45;
    tick();
    waitDone(lat);
    checkOutput("cfg_wins done",       32'(done),    32'd1);
    checkOutput("cfg_wins pass",       32'(pass),    32'd0);
    checkOutput("cfg_wins failIdx",    32'(failIdx), 32'd0);
    checkOutput("cfg_wins writeCount", writeCount,   32'd1);

    // PC never repeats: timeout forced when cycleCount was TO-1.
    applyReset();
    for (int n = 1; n <= TO + NC; n++) begin
      tick();
      if (n == TO - 1)      checkOutput("timeout early",    32'(timeout), 32'd0);
      if (n == TO)          checkOutput("timeout set",      32'(timeout), 32'd1);
      if (n == TO + NC - 1) checkOutput("timeout not_done", 32'(done),    32'd0);
    end
    checkOutput("timeout done",       32'(done),    32'd1);
    checkOutput("timeout pass",       32'(pass),    32'd0);
    checkOutput("timeout flag",       32'(timeout), 32'd1);
    checkOutput("timeout cycleCount", cycleCount,   32'(TO));
    repeat (3) tick();
    checkOutput("timeout cycleCount_held", cycleCount, 32'(TO));

    // Halt count completes on the same edge the timeout condition holds: halt wins.
    applyReset();
    holdAt = TO - HR;
    for (int n = 1; n <= TO + NC; n++) begin
      tick();
      if (n == TO + NC - 1) checkOutput("halt_wins not_done", 32'(done), 32'd0);
    end
    checkOutput("halt_wins done",       32'(done),    32'd1);
    checkOutput("halt_wins timeout",    32'(timeout), 32'd0);
    checkOutput("halt_wins pass",       32'(pass),    32'd1);
    checkOutput("halt_wins cycleCount", cycleCount,   32'(TO));

    // Reset mid-CHECK after failIdx has latched, then rerun without reconfiguring old entries.
    applyReset();
    applyStimulus(5);
    holdAt = edgeNo + 1;
    repeat (HR + 3) tick();
    checkOutput("midcheck failIdx_latched", 32'(failIdx), 32'd1);
    checkOutput("midcheck not_done",        32'(done),    32'd0);
    applyReset();
    checkOutput("midcheck_reset done",       32'(done),    32'd0);
    checkOutput("midcheck_reset pass",       32'(pass),    32'd0);
    checkOutput("midcheck_reset timeout",    32'(timeout), 32'd0);
    checkOutput("midcheck_reset failIdx",    32'(failIdx), 32'd0);
    checkOutput("midcheck_reset cycleCount", cycleCount,   32'd0);
    checkOutput("midcheck_reset writeCount", writeCount,   32'd0);
    applyStimulus(0);
    waitDone(lat);
    checkOutput("rerun done",    32'(done),    32'd1);
    checkOutput("rerun latency", 32'(lat),     32'(HR + NC + 1));
    checkOutput("rerun pass",    32'(pass),    32'd1);
    checkOutput("rerun failIdx", 32'(failIdx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
